// File: rtl/dispatcher_round_robin_pkg.sv
// Shared helpers for the round-robin dispatcher.
// Pure functions only; no state.
package dispatcher_round_robin_pkg;

  // Modulo-n increment used for pointer advance.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/dispatcher_round_robin_rr_first_free.sv
// Purpose: pick the first free lane scanning from ptr upward with wrap.
// Latency: purely combinational.
// Backpressure: any_free low when no lane can take a word.
module rr_first_free #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     free,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] idx,
  output logic             any_free
);

  localparam logic [PTR_W:0] N_EXT = (PTR_W+1)'(N);

  logic [N-1:0]     rot;
  logic [PTR_W-1:0] off;
  logic             found;
  logic [PTR_W:0]   sum;

  // Rotating the doubled vector puts lane ptr at bit 0, so a plain
  // lowest-set-bit encoder yields the offset from ptr.
  assign rot = N'({free, free} >> ptr);

  always_comb begin
    off   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = PTR_W'(i);
      end
    end
  end

  always_comb begin
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= N_EXT) sum = sum - N_EXT;
  end

  assign idx      = sum[PTR_W-1:0];
  assign any_free = |free;
  assign grant    = any_free ? (N'(1) << idx) : '0;

endmodule

// File: rtl/dispatcher_round_robin.sv
// Purpose: 1-to-N stream fan-out, round-robin over lanes able to take a word.
// Latency: 1 cycle, word accepted at edge t is on its lane from cycle t+1.
// Backpressure: in_ready is combinational from out_ready; low when all lanes full.
module dispatcher_round_robin
  import dispatcher_round_robin_pkg::*;
#(
  parameter int DWIDTH          = 16,
  parameter int N               = 2,
  parameter int INIT_FIRST_PRIO = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DWIDTH-1:0]        in_data,
  output logic                     in_ready,
  input  logic                     shift,
  output logic                     out_valid [N],
  output logic [DWIDTH-1:0]        out_data  [N],
  input  logic                     out_ready [N],
  output logic [$clog2(N+1)-1:0]   occupancy
);

  localparam int PTR_W = $clog2(N);
  localparam int CNT_W = $clog2(N+1);

  logic [N-1:0]     free;
  logic [N-1:0]     gnt;
  logic [PTR_W-1:0] gnt_idx;
  logic             any_free;
  logic [PTR_W-1:0] ptr;
  logic             xfer;
  logic [CNT_W-1:0] n_drain;
  logic [CNT_W-1:0] occ_next;

  always_comb begin
    free = '0;
    for (int i = 0; i < N; i++) free[i] = !out_valid[i] || out_ready[i];
  end

  rr_first_free #(.N(N), .PTR_W(PTR_W)) u_pick (
    .free     (free),
    .ptr      (ptr),
    .grant    (gnt),
    .idx      (gnt_idx),
    .any_free (any_free)
  );

  assign in_ready = any_free && !rst;
  assign xfer     = in_valid && in_ready;

  // A refilled lane counts as one drain plus one transfer, netting zero.
  always_comb begin
    n_drain = '0;
    for (int i = 0; i < N; i++) begin
      if (out_valid[i] && out_ready[i]) n_drain = n_drain + CNT_W'(1);
    end
    occ_next = occupancy + CNT_W'(xfer) - n_drain;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        out_valid[i] <= 1'b0;
        out_data[i]  <= '0;
      end
      ptr       <= PTR_W'(INIT_FIRST_PRIO);
      occupancy <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (xfer && gnt[i]) begin
          out_valid[i] <= 1'b1;
          out_data[i]  <= in_data;
        end else if (out_valid[i] && out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
      if (xfer)       ptr <= PTR_W'(wrap_inc(32'(gnt_idx), N));
      else if (shift) ptr <= PTR_W'(wrap_inc(32'(ptr), N));
      occupancy <= occ_next;
    end
  end

endmodule

// File: tb/tb_dispatcher_round_robin.sv
// Bench for dispatcher_round_robin: directed vector table, hand sequences,
// and randomized traffic against a lane-array reference model.
module tb_dispatcher_round_robin;

  localparam int N  = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          shift = 1'b0;
  logic          out_valid [N];
  logic [DW-1:0] out_data  [N];
  logic          out_ready [N];
  logic [2:0]    occupancy;

  always #5 clk = ~clk;

  dispatcher_round_robin #(.DWIDTH(DW), .N(N), .INIT_FIRST_PRIO(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .shift     (shift),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  // Reference model: per-lane holding slot, priority pointer as an integer.
  bit          m_valid [N];
  logic [DW-1:0] m_data [N];
  int          m_ptr;

  int errors = 0;
  int checks = 0;
  logic seen_ir;

  typedef struct {
    logic          r;
    logic          v;
    logic [DW-1:0] d;
    logic          s;
    logic [3:0]    rdy;
    logic          ir;
    int            lane;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_data[i]  = '0;
    end
    m_ptr = 0;
  endtask

  // One clock of stimulus; checks in_ready before the edge and every output after.
  task automatic step(input logic r, input logic v, input logic [DW-1:0] d,
                      input logic s, input logic [3:0] rdy);
    int g;
    int cnt;
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; shift = s;
    for (int i = 0; i < N; i++) out_ready[i] = rdy[i];
    #1;
    g = -1;
    if (!r) begin
      for (int k = 0; k < N; k++) begin
        int l;
        l = (m_ptr + k) % N;
        if (g < 0 && (!m_valid[l] || rdy[l])) g = l;
      end
    end
    seen_ir = in_ready;
    check("in_ready", 32'(in_ready), 32'(g >= 0));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++) if (m_valid[i] && rdy[i]) m_valid[i] = 1'b0;
      if (v && g >= 0) begin
        m_valid[g] = 1'b1;
        m_data[g]  = d;
        m_ptr      = (g + 1) % N;
      end else if (s) begin
        m_ptr = (m_ptr + 1) % N;
      end
    end
    #1;
    cnt = 0;
    for (int i = 0; i < N; i++) begin
      check($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(m_valid[i]));
      check($sformatf("out_data[%0d]", i), 32'(out_data[i]), 32'(m_data[i]));
      if (m_valid[i]) cnt++;
    end
    check("occupancy", 32'(occupancy), 32'(cnt));
  endtask

  initial begin
    for (int i = 0; i < N; i++) out_ready[i] = 1'b0;
    model_reset();

    // r, v, data, shift, out_ready, exp in_ready, exp lane (-1 none)
    tbl.push_back('{1, 0, 16'h0000, 0, 4'b0000, 0, -1});
    tbl.push_back('{1, 0, 16'h0000, 0, 4'b0000, 0, -1});
    tbl.push_back('{0, 1, 16'h000A, 0, 4'b0000, 1,  0});
    tbl.push_back('{0, 1, 16'h000B, 0, 4'b0000, 1,  1});
    tbl.push_back('{0, 1, 16'h000C, 0, 4'b0000, 1,  2});
    tbl.push_back('{0, 1, 16'h000D, 0, 4'b0000, 1,  3});
    tbl.push_back('{0, 1, 16'h000E, 0, 4'b0000, 0, -1});
    tbl.push_back('{0, 1, 16'h2222, 0, 4'b0100, 1,  2});
    tbl.push_back('{0, 0, 16'h0000, 1, 4'b1101, 1, -1});
    tbl.push_back('{0, 1, 16'h0101, 0, 4'b1101, 1,  0});
    tbl.push_back('{0, 1, 16'h0102, 0, 4'b1101, 1,  2});
    tbl.push_back('{0, 1, 16'h0103, 0, 4'b1101, 1,  3});
    tbl.push_back('{0, 1, 16'h0104, 0, 4'b1101, 1,  0});
    tbl.push_back('{0, 1, 16'h0105, 0, 4'b1101, 1,  2});
    tbl.push_back('{0, 1, 16'h0106, 0, 4'b1101, 1,  3});
    tbl.push_back('{0, 1, 16'h0107, 0, 4'b1101, 1,  0});
    tbl.push_back('{0, 0, 16'h0000, 0, 4'b1111, 1, -1});
    tbl.push_back('{1, 0, 16'h0000, 0, 4'b1111, 0, -1});
    tbl.push_back('{0, 0, 16'h0000, 1, 4'b0000, 1, -1});
    tbl.push_back('{0, 0, 16'h0000, 1, 4'b0000, 1, -1});
    tbl.push_back('{0, 1, 16'h0333, 0, 4'b0000, 1,  2});
    tbl.push_back('{0, 0, 16'h0000, 0, 4'b0100, 1, -1});
    tbl.push_back('{0, 0, 16'h0000, 1, 4'b0000, 1, -1});
    tbl.push_back('{0, 0, 16'h0000, 1, 4'b0000, 1, -1});
    tbl.push_back('{0, 0, 16'h0000, 1, 4'b0000, 1, -1});
    tbl.push_back('{0, 1, 16'h0444, 1, 4'b0000, 1,  2});
    tbl.push_back('{0, 1, 16'h0555, 0, 4'b0000, 1,  3});
    tbl.push_back('{0, 1, 16'h0666, 0, 4'b0000, 1,  0});
    tbl.push_back('{1, 1, 16'h0777, 0, 4'b0000, 0, -1});
    tbl.push_back('{0, 1, 16'h0888, 0, 4'b0000, 1,  0});

    foreach (tbl[n]) begin
      step(tbl[n].r, tbl[n].v, tbl[n].d, tbl[n].s, tbl[n].rdy);
      check($sformatf("vec%0d in_ready", n), 32'(seen_ir), 32'(tbl[n].ir));
      if (tbl[n].lane >= 0) begin
        check($sformatf("vec%0d lane_valid", n), 32'(out_valid[tbl[n].lane]), 32'd1);
        check($sformatf("vec%0d lane_data", n), 32'(out_data[tbl[n].lane]), 32'(tbl[n].d));
      end
      if (n == 6) check("full occupancy", 32'(occupancy), 32'd4);
    end

    // Lane 0 held under backpressure while the other lanes keep flowing.
    step(1, 0, 16'h0000, 0, 4'b0000);
    step(0, 1, 16'hBEEF, 0, 4'b0000);
    for (int c = 0; c < 10; c++) begin
      step(0, 1, 16'($urandom), 0, 4'b1110);
      check("hold valid0", 32'(out_valid[0]), 32'd1);
      check("hold data0", 32'(out_data[0]), 32'hBEEF);
    end

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), 16'($urandom),
           ($urandom_range(0, 4) == 0), 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dispatcher_round_robin.md
# dispatcher_round_robin

One-to-N stream dispatcher: accepts a single valid/ready stream and hands each word to exactly one of N output lanes, selected round-robin among lanes able to take data. It is the fan-out counterpart of the N-to-1 arbiters. It feeds work words from a shared front end into N parallel engine cores. Each lane has a one-entry output register, so data and valid outputs are registered.

## Interface
- DWIDTH, 16, data word width.
- N, 2, number of output lanes; N ≥ 2.
- INIT_FIRST_PRIO, 0, lane holding highest priority after reset; 0 ≤ INIT_FIRST_PRIO < N.

- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word present.
- in_data  in  DWIDTH  input word.
- in_ready  out  1  input word accepted this cycle when in_valid & in_ready.
- shift  in  1  advance priority pointer by one without a transfer.
- out_valid  out  1 [N-1:0]  per-lane word present (unpacked array).
- out_data  out  DWIDTH [N-1:0]  per-lane word (unpacked array).
- out_ready  in  1 [N-1:0]  per-lane consumer ready.
- occupancy  out  $clog2(N+1)  number of lanes currently holding a word.

## Operation
- State: lane_valid[i], lane_data[i], priority pointer ptr (width $clog2(N)), occupancy counter.
- Lane i is free when !lane_valid[i] | out_ready[i]. Drain-and-refill in the same cycle is allowed.
- in_ready = |free and !rst. This is a combinational path from out_ready to in_ready.
- Grant: the first free lane scanning ptr, ptr+1, …, N-1, 0, …, ptr-1. At most one grant per cycle.
- On transfer (in_valid & in_ready) to lane g: lane_valid[g] ← 1, lane_data[g] ← in_data, ptr ← (g+1) mod N.
- Lane drain (lane_valid[i] & out_ready[i]) without refill: lane_valid[i] ← 0. lane_data holds its last value.
- shift without transfer: ptr ← (ptr+1) mod N. If a transfer occurs in the same cycle, the transfer update wins and shift is ignored.
- occupancy ← occupancy + (transfer) − (number of drains, without refill counting twice). It always equals the popcount of lane_valid. The arithmetic is done at width $clog2(N+1) and never wraps.
- Wrap-around: ptr increment from N-1 goes to 0.
- Invariant: out_valid[i] = lane_valid[i]. out_data[i] stays stable while out_valid[i] & !out_ready[i].

## Timing
- Reset (rst high at an edge): lane_valid all 0, lane_data all 0, ptr = INIT_FIRST_PRIO, occupancy = 0. in_ready is 0 during every cycle rst is high.
- Reset mid-operation discards all held words with no drain handshake. The first cycle after rst deasserts shows in_ready = 1.
- Latency: word accepted at edge t appears on out_valid/out_data of its lane from cycle t+1.
- Throughput: one word per cycle while any lane is free.
- All full (every lane valid, no out_ready): in_ready = 0; ptr and state hold. A shift still advances ptr.
- All empty: the grant goes to lane ptr.
- out_* are registered. in_ready is the only combinational output.

## Structure
- No shared package additions. PTR_W = $clog2(N) and CNT_W = $clog2(N+1) are local parameters.
- Sub-module rr_first_free, purely combinational:
  - inputs: free vector, ptr.
  - outputs: one-hot grant, granted index, any_free.
  - implementation: double-width rotate-and-priority-encode.
- The top level holds the lane registers, the pointer, and the occupancy counter.

## Test plan
- Reset/idle, N=4, INIT_FIRST_PRIO=0, all out_ready=0: after reset, send A,B,C,D on consecutive cycles -> lanes 0,1,2,3 each valid one cycle after acceptance. in_ready drops the cycle after D. occupancy=4.
- Round-robin with skip, N=4, lane 1 held busy: stream 6 words with other lanes always ready -> lane sequence 0,2,3,0,2,3. ptr after the last grant = 0.
- Drain-and-refill: all lanes full, out_ready[2]=1 for one cycle with in_valid=1 -> the same cycle has in_ready=1, the new word lands in lane 2, and occupancy stays 4.
- Shift: idle with ptr=0, pulse shift twice, then send one word -> it goes to lane 2. Shift in the same cycle as a transfer to lane 2 -> ptr=3, not 4 mod N.
- Backpressure stability: lane 0 holds 0xBEEF with out_ready[0]=0 for 10 cycles while other traffic flows -> out_data[0] stays 0xBEEF and out_valid[0]=1 throughout.
- Mid-operation reset with 3 lanes full, rst high for one cycle -> all out_valid=0, occupancy=0, in_ready=0 during reset and 1 the next cycle, and the next word goes to lane INIT_FIRST_PRIO.
